// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES UART command controller: frame command
// codes, response status codes, controller states and counter widths.
package aes_uart_pkg;

    localparam int BLK_W           = 128;
    localparam int TIMEOUT_DEFAULT = 1_000_000;
    localparam int CNT_W           = $clog2(TIMEOUT_DEFAULT + 1);

    localparam logic [7:0] CMD_SET_KEY = 8'h00;
    localparam logic [7:0] CMD_ENC     = 8'h02;
    localparam logic [7:0] CMD_DEC     = 8'h03;

    localparam logic [7:0] ST_KEY_OK   = 8'h80;
    localparam logic [7:0] ST_ENC_OK   = 8'h82;
    localparam logic [7:0] ST_DEC_OK   = 8'h83;
    localparam logic [7:0] ST_NO_KEY   = 8'hE0;
    localparam logic [7:0] ST_BAD_CMD  = 8'hEE;
    localparam logic [7:0] ST_TIMEOUT  = 8'hEF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RX_PAY    = 3'd1,
        S_CORE_GO   = 3'd2,
        S_CORE_WAIT = 3'd3,
        S_TX_STAT   = 3'd4,
        S_TX_DATA   = 3'd5
    } state_t;

    // True for the three command codes that carry a 16-byte payload.
    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_SET_KEY) || (cmd == CMD_ENC) || (cmd == CMD_DEC);
    endfunction

    // True for status codes that are followed by a 16-byte result block.
    function automatic logic has_result(input logic [7:0] stat);
        return (stat == ST_ENC_OK) || (stat == ST_DEC_OK);
    endfunction

endpackage

// File: rtl/aes_blk_shreg.sv
// 128-bit block register shared by RX assembly and TX serialization:
// parallel load from the core result, or byte shift toward the MSB end
// (new byte enters at the LSB end, outgoing byte leaves from the MSB end).
module aes_blk_shreg
    import aes_uart_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_load,
    input  logic [BLK_W-1:0] i_load_data,
    input  logic             i_shift,
    input  logic [7:0]       i_shift_in,
    output logic [BLK_W-1:0] o_q
);

    logic [BLK_W-1:0] r_q;

    // Block storage: parallel load has priority over the byte shift.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_q <= {BLK_W{1'b0}};
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {r_q[BLK_W-9:0], i_shift_in};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/aes_cmd_ctrl.sv
// Host command framing controller: parses UART command frames, launches
// key load / encrypt / decrypt on the AES core and returns a status byte
// plus, for successful encrypt/decrypt, the 16-byte result.
module aes_cmd_ctrl
    import aes_uart_pkg::*;
#(
    parameter int DW             = BLK_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_RxDone,
    input  logic [7:0]    i_RxData,
    output logic          o_TxStart,
    output logic [7:0]    o_TxData,
    input  logic          i_TxReady,
    input  logic          i_TxDone,
    output logic          o_fKey,
    output logic          o_fEnc,
    output logic          o_fDec,
    output logic [DW-1:0] o_Key,
    output logic [DW-1:0] o_Data,
    input  logic          i_CoreDone,
    input  logic [DW-1:0] i_CoreData
);

    // Last count value before the idle window expires.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cmd, w_cmd_nxt;
    logic [7:0]       r_stat, w_stat_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_to_cnt, w_to_nxt;
    logic             r_tx_busy, w_tx_busy_nxt;
    logic             r_key_valid, w_key_valid_nxt;
    logic             r_fkey, w_fkey_nxt;
    logic             r_fenc, w_fenc_nxt;
    logic             r_fdec, w_fdec_nxt;
    logic             r_txstart, w_txstart_nxt;
    logic [7:0]       r_txdata, w_txdata_nxt;
    logic [DW-1:0]    r_key, r_data;
    logic             w_key_load, w_data_load;
    logic             w_sh_load, w_sh_shift;
    logic [7:0]       w_sh_in;
    logic [DW-1:0]    w_sh_q;
    logic [DW-1:0]    w_shift_val;

    // Block as it will look once the byte currently on i_RxData is shifted in.
    assign w_shift_val = {w_sh_q[DW-9:0], i_RxData};

    aes_blk_shreg u_shreg (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_load      (w_sh_load),
        .i_load_data (i_CoreData),
        .i_shift     (w_sh_shift),
        .i_shift_in  (w_sh_in),
        .o_q         (w_sh_q)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, handshake and pulse decode; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_stat_nxt      = r_stat;
        w_cnt_nxt       = r_cnt;
        w_to_nxt        = r_to_cnt;
        w_tx_busy_nxt   = r_tx_busy;
        w_key_valid_nxt = r_key_valid;
        w_fkey_nxt      = 1'b0;
        w_fenc_nxt      = 1'b0;
        w_fdec_nxt      = 1'b0;
        w_txstart_nxt   = 1'b0;
        w_txdata_nxt    = r_txdata;
        w_key_load      = 1'b0;
        w_data_load     = 1'b0;
        w_sh_load       = 1'b0;
        w_sh_shift      = 1'b0;
        w_sh_in         = i_RxData;
        case (r_state)
            S_IDLE: begin
                if (i_RxDone) begin
                    w_cmd_nxt = i_RxData;
                    w_cnt_nxt = 4'd0;
                    w_to_nxt  = {CNT_W{1'b0}};
                    if (is_known_cmd(i_RxData)) begin
                        w_state_nxt = S_RX_PAY;
                    end else begin
                        w_stat_nxt  = ST_BAD_CMD;
                        w_state_nxt = S_TX_STAT;
                    end
                end else begin
                    w_to_nxt = {CNT_W{1'b0}};
                end
            end
            S_RX_PAY: begin
                // A byte arriving in the expiry cycle wins over the timeout.
                if (i_RxDone) begin
                    w_sh_shift = 1'b1;
                    w_to_nxt   = {CNT_W{1'b0}};
                    if (r_cnt == 4'd15) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_CORE_GO;
                        if (r_cmd == CMD_SET_KEY) begin
                            w_key_load = 1'b1;
                            w_fkey_nxt = 1'b1;
                        end else begin
                            w_data_load = 1'b1;
                            w_fenc_nxt  = r_key_valid && (r_cmd == CMD_ENC);
                            w_fdec_nxt  = r_key_valid && (r_cmd == CMD_DEC);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_nxt    = {CNT_W{1'b0}};
                    w_cnt_nxt   = 4'd0;
                    w_stat_nxt  = ST_TIMEOUT;
                    w_state_nxt = S_TX_STAT;
                end else begin
                    w_to_nxt = r_to_cnt + CNT_W'(1);
                end
            end
            S_CORE_GO: begin
                // The start pulse is visible during this cycle.
                if ((r_cmd != CMD_SET_KEY) && !r_key_valid) begin
                    w_stat_nxt  = ST_NO_KEY;
                    w_state_nxt = S_TX_STAT;
                end else begin
                    w_state_nxt = S_CORE_WAIT;
                end
            end
            S_CORE_WAIT: begin
                if (i_CoreDone) begin
                    w_sh_load   = 1'b1;
                    w_state_nxt = S_TX_STAT;
                    if (r_cmd == CMD_SET_KEY) begin
                        w_key_valid_nxt = 1'b1;
                        w_stat_nxt      = ST_KEY_OK;
                    end else if (r_cmd == CMD_ENC) begin
                        w_stat_nxt = ST_ENC_OK;
                    end else begin
                        w_stat_nxt = ST_DEC_OK;
                    end
                end else begin
                    w_state_nxt = S_CORE_WAIT;
                end
            end
            S_TX_STAT: begin
                if (!r_tx_busy) begin
                    if (i_TxReady) begin
                        w_txstart_nxt = 1'b1;
                        w_txdata_nxt  = r_stat;
                        w_tx_busy_nxt = 1'b1;
                    end else begin
                        w_tx_busy_nxt = 1'b0;
                    end
                end else if (i_TxDone) begin
                    w_tx_busy_nxt = 1'b0;
                    w_cnt_nxt     = 4'd0;
                    if (has_result(r_stat)) begin
                        w_state_nxt = S_TX_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tx_busy_nxt = 1'b1;
                end
            end
            S_TX_DATA: begin
                if (!r_tx_busy) begin
                    if (i_TxReady) begin
                        w_txstart_nxt = 1'b1;
                        w_txdata_nxt  = w_sh_q[DW-1:DW-8];
                        w_sh_shift    = 1'b1;
                        w_sh_in       = 8'h00;
                        w_tx_busy_nxt = 1'b1;
                    end else begin
                        w_tx_busy_nxt = 1'b0;
                    end
                end else if (i_TxDone) begin
                    w_tx_busy_nxt = 1'b0;
                    if (r_cnt == 4'd15) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_tx_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_tx_busy_nxt = 1'b0;
            end
        endcase
    end

    // Frame bookkeeping, handshake flags and registered output pulses.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cmd       <= 8'h00;
            r_stat      <= 8'h00;
            r_cnt       <= 4'd0;
            r_to_cnt    <= {CNT_W{1'b0}};
            r_tx_busy   <= 1'b0;
            r_key_valid <= 1'b0;
            r_fkey      <= 1'b0;
            r_fenc      <= 1'b0;
            r_fdec      <= 1'b0;
            r_txstart   <= 1'b0;
            r_txdata    <= 8'h00;
        end else begin
            r_cmd       <= w_cmd_nxt;
            r_stat      <= w_stat_nxt;
            r_cnt       <= w_cnt_nxt;
            r_to_cnt    <= w_to_nxt;
            r_tx_busy   <= w_tx_busy_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_fkey      <= w_fkey_nxt;
            r_fenc      <= w_fenc_nxt;
            r_fdec      <= w_fdec_nxt;
            r_txstart   <= w_txstart_nxt;
            r_txdata    <= w_txdata_nxt;
        end
    end

    // Key and operand holding registers, stable until the next complete frame.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_key  <= {DW{1'b0}};
            r_data <= {DW{1'b0}};
        end else begin
            r_key  <= w_key_load  ? w_shift_val : r_key;
            r_data <= w_data_load ? w_shift_val : r_data;
        end
    end

    assign o_TxStart = r_txstart;
    assign o_TxData  = r_txdata;
    assign o_fKey    = r_fkey;
    assign o_fEnc    = r_fenc;
    assign o_fDec    = r_fdec;
    assign o_Key     = r_key;
    assign o_Data    = r_data;

endmodule

// File: doc/aes_cmd_ctrl.md
# aes_cmd_ctrl

Command/framing controller between the UART byte interfaces and the AES-128 core inside the AES top level. It parses host command frames arriving byte-by-byte from the UART receiver, assembles 128-bit key/data blocks, and launches key load, encrypt or decrypt on the core. It then serializes a status byte and, for encrypt/decrypt, the 16-byte result back through the UART transmitter.

## Interface
- DW, 128, block width in bits; fixed at 128.
- TIMEOUT_CYCLES, 1_000_000, max idle cycles between payload bytes before the frame is abandoned.
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- i_RxDone  in  1  one-cycle pulse: i_RxData holds a received byte.
- i_RxData  in  8  received byte.
- o_TxStart  out  1  one-cycle pulse: transmit o_TxData.
- o_TxData  out  8  byte to transmit; held stable until i_TxDone.
- i_TxReady  in  1  transmitter idle.
- i_TxDone  in  1  one-cycle pulse: byte fully sent.
- o_fKey  out  1  one-cycle pulse: core latches o_Key and expands it.
- o_fEnc / o_fDec  out  1 each  one-cycle start pulses; o_Data is valid in the same cycle.
- o_Key  out  128  assembled key.
- o_Data  out  128  assembled plaintext/ciphertext.
- i_CoreDone  in  1  one-cycle pulse: key expansion or block operation finished.
- i_CoreData  in  128  core result; valid while i_CoreDone is high.

## Operation
- Frame format: 1 command byte, then 16 payload bytes, first byte = bits [127:120]. Commands: 8'h00 SET_KEY, 8'h02 ENC, 8'h03 DEC.
- Response: 1 status byte. ENC/DEC with status OK are followed by 16 result bytes, MSB byte first.
- Status codes: 8'h80 key OK; 8'h82 enc OK; 8'h83 dec OK; 8'hE0 no key loaded; 8'hEE unknown command; 8'hEF timeout.
- States:
  - IDLE: wait for a command byte. An unknown command goes to TX_STAT with 8'hEE; no payload is consumed.
  - RX_PAY: shift in 16 bytes. A 4-bit counter counts 0..15. On byte 15 go to CORE_GO.
  - CORE_GO: pulse o_fKey, o_fEnc or o_fDec, then go to CORE_WAIT. ENC/DEC with key_valid=0 instead goes straight to TX_STAT with 8'hE0.
  - CORE_WAIT: on i_CoreDone, capture i_CoreData into the shift register. A SET_KEY completion sets key_valid. Then go to TX_STAT.
  - TX_STAT: wait for i_TxReady, pulse o_TxStart, wait for i_TxDone. Then go to TX_DATA for ENC/DEC OK, otherwise IDLE.
  - TX_DATA: send 16 bytes with the same handshake, then go to IDLE.
- Timeout: in RX_PAY, a counter resets on every i_RxDone. When it reaches TIMEOUT_CYCLES, send 8'hEF, discard the payload and go to IDLE. key_valid is unchanged.
- Bytes received in any state other than IDLE or RX_PAY are dropped silently.
- key_valid is cleared only by reset. A new SET_KEY overwrites the key.

## Timing
- Reset (async assert) drives every output to 0, the state to IDLE, key_valid to 0, and clears all counters and registers. Reset mid-frame or mid-transmit abandons the frame with no response.
- i_RxDone for payload byte 15 in cycle n → start pulse in cycle n+1. o_Key/o_Data are stable from n+1 until the next frame.
- i_CoreDone in cycle m → o_TxStart no earlier than m+1, gated by i_TxReady.
- Consecutive TX bytes: o_TxStart is issued no earlier than 1 cycle after i_TxDone. Exactly one o_TxStart per byte.
- i_RxDone and timeout expiry in the same cycle: the byte wins and the counter resets.
- Only one start pulse is ever asserted at a time.

## Structure
- Package aes_uart_pkg holds: command codes, status codes, the state enum, and the counter width ($clog2(TIMEOUT_CYCLES+1)).
- Sub-module aes_blk_shreg: 128-bit register with parallel load (from i_CoreData) and 8-bit shift-in at the LSB end / shift-out from the MSB end. It is used for both RX assembly and TX serialization. The key is held in a separate 128-bit register loaded from it.

## Test plan
- SET_KEY with 5468617473206D79204B756E67204675 → o_fKey with o_Key equal to that value; after i_CoreDone, TX 8'h80.
- After the key, ENC 54776F204F6E65204E696E652054776F with a core model → TX 8'h82, then 29C3505F571420F6402299B31A02D73A MSB first.
- After the key, DEC 29C3505F571420F6402299B31A02D73A → TX 8'h83, then 54776F204F6E65204E696E652054776F.
- ENC after reset with no key → 16 bytes consumed, TX 8'hE0 only, no o_fEnc.
- Command 8'h05 → TX 8'hEE immediately. A following valid SET_KEY frame is parsed correctly.
- SET_KEY then 5 bytes then silence beyond TIMEOUT_CYCLES → TX 8'hEF, no o_fKey. Separately, Rst low during TX_DATA → outputs 0, state IDLE, key_valid 0.
